hazard_scoreboard: RTL
======================

# hazard_scoreboard

Pipeline hazard controller for the five-stage MIPS core. It keeps a three-entry scoreboard that mirrors the destination register and remaining result latency (Tnew) of the instructions in E, M and W. From that scoreboard it produces the D-stage stall, D-stage and E-stage forwarding selects, and the multiply/divide stall that keeps the E-stage mult/div unit from receiving an MD instruction while it is occupied. It sits beside the D/E pipeline register, directly upstream of the E-stage MD unit, and consumes that unit's start/busy outputs.

## Interface
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears scoreboard
- req  in  1  interrupt/exception request; flushes in-flight instructions
- d_valid  in  1  D holds a real instruction (0 = bubble)
- d_rs, d_rt  in  5 each  D source registers
- d_tuse_rs, d_tuse_rt  in  2 each  cycles until D needs the operand (0..2); 3 = operand unused
- d_dst  in  5  destination register; 0 = no write
- d_tnew  in  2  cycles from E entry until result is ready (jal=0, ALU=1, load=2)
- d_is_md  in  1  D is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- md_start  in  1  E-stage MD unit starting an operation this cycle
- md_busy  in  1  E-stage MD unit counting down
- stall  out  1  freeze PC and F/D, insert bubble into D/E
- fwd_d_rs, fwd_d_rt  out  2 each  D operand source: 0 regfile, 1 E result, 2 M result
- fwd_e_rs, fwd_e_rt  out  2 each  E operand source: 0 D/E register, 1 M result, 2 W result

## Operation
- Entry fields: valid, dst[4:0], tnew[1:0]. The E entry also holds rs[4:0] and rt[4:0].
- An entry matches register r when valid && dst==r && r!=0.
- Data stall: for each used operand (tuse≠3), stall when E matches with E.tnew > tuse, or M matches with M.tnew > tuse. W never stalls because its tnew is always 0.
- MD stall: d_valid && d_is_md && (md_busy || md_start).
- stall = d_valid && (data stall || MD stall).
- fwd_d_x: 1 if E matches with E.tnew==0; else 2 if M matches with M.tnew==0; else 0. The nearer stage wins.
- fwd_e_x uses E.rs or E.rt: 1 if M matches with M.tnew==0; else 2 if W matches; else 0.
- Forwarding is only meaningful when stall==0. It is computed regardless.

## Timing
- All outputs are combinational from the scoreboard, the D-side inputs and md_start/md_busy. There is no output register.
- Update on posedge clk, in priority order:
  - reset=1: all valid bits cleared, all fields 0. After reset: stall=0 and every fwd output = 0.
  - req=1: E, M and W all cleared to bubble. The instruction in M is the exception victim and must not be seen as a producer.
  - normal update:
    - W←M; W.tnew forced to 0.
    - M←E; M.tnew = sat(E.tnew−1) at 0.
    - E←D entry when stall=0: valid=d_valid&&d_dst≠0, tnew=d_tnew, plus rs/rt/dst. When stall=1, E←bubble.
- Latency: a load (tnew=2) followed immediately by a consumer with tuse=1 gives 1 stall cycle. With tuse=0 it gives 2 stall cycles.
- MD stall lasts every cycle md_busy=1, plus the md_start cycle. An MD op followed by mflo stalls for 1 + 5 cycles (mult) or 1 + 10 cycles (div).
- If req and stall are asserted together, req wins and E is cleared.
- A bubble into E (stall or d_valid=0) must never match. Register 0 never matches.

## Structure
- Shared package `hazard_pkg` holds:
  - forwarding select constants: FWD_RF=0, FWD_E=1, FWD_M=2, FWD_W=2
  - TUSE_NONE=3
  - entry typedef {valid, dst, tnew}
- One sub-module, `sb_match`: combinational (entry, reg, tuse) → {match, ready, stall_req}. It is instantiated once per stage and per operand.

## Test plan
- Reset mid-run with E.dst=$8, tnew=2 → next cycle stall=0 and every fwd output = 0 for d_rs=$8, tuse=0.
- lw $8 then addu $9,$8,$0 (tuse_rs=1) → stall=1 for exactly 1 cycle, then fwd_d_rs=0 and fwd_e_rs=2 (W).
- addu $8 then beq $8 (tuse=0) → stall 1 cycle, then fwd_d_rs=2 (M).
- jal (dst=31, tnew=0) then jr $31 → no stall, fwd_d_rs=1.
- mult (md_start=1), then md_busy=1 for 5 cycles, with mflo in D → stall asserted 6 consecutive cycles, released when md_busy=0.
- lw $8 in E and req=1 → next cycle a consumer of $8 with tuse=0 sees stall=0 and fwd_d_rs=0; $0 as d_dst never forwards.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard.
// Forwarding select encodings, the "operand unused" Tuse marker and the scoreboard entry.
package hazard_pkg;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_E     = 2'd1;
    localparam logic [1:0] FWD_M     = 2'd2;
    localparam logic [1:0] FWD_W     = 2'd2;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic [1:0] tnew;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, dst: 5'd0, tnew: 2'd0};

    // Remaining latency one stage later, saturating at zero.
    function automatic logic [1:0] tnew_advance(input logic [1:0] tnew);
        return (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_match.sv
// Compares one scoreboard entry against one source register.
// Reports a match, whether the result is ready now, and whether the consumer must wait.
module sb_match
    import hazard_pkg::*;
(
    input  logic       valid_i,
    input  logic [4:0] dst_i,
    input  logic [1:0] tnew_i,
    input  logic [4:0] reg_i,
    input  logic [1:0] tuse_i,
    output logic       match_o,
    output logic       ready_o,
    output logic       stall_req_o
);

    assign match_o     = valid_i && (dst_i == reg_i) && (reg_i != 5'd0);
    assign ready_o     = match_o && (tnew_i == 2'd0);
    assign stall_req_o = match_o && (tuse_i != TUSE_NONE) && (tnew_i > tuse_i);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard controller for the five-stage core: tracks producers in E, M and W and
// derives the D-stage stall plus D- and E-stage forwarding selects.
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       d_valid,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_dst,
    input  logic [1:0] d_tnew,
    input  logic       d_is_md,
    input  logic       md_start,
    input  logic       md_busy,
    output logic       stall,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt
);

    sb_entry_t  e_q, e_d, m_q, m_d, w_q, w_d;
    logic [4:0] e_rs_q, e_rs_d, e_rt_q, e_rt_d;

    logic [4:0] d_reg  [2];
    logic [1:0] d_tuse [2];
    logic [4:0] e_reg  [2];

    logic [1:0] d_e_match, d_e_rdy, d_e_stl;
    logic [1:0] d_m_match, d_m_rdy, d_m_stl;
    logic [1:0] e_m_match, e_m_rdy, e_m_stl;
    logic [1:0] e_w_match, e_w_rdy, e_w_stl;

    logic data_stall, md_stall;

    assign d_reg[0]  = d_rs;
    assign d_reg[1]  = d_rt;
    assign d_tuse[0] = d_tuse_rs;
    assign d_tuse[1] = d_tuse_rt;
    assign e_reg[0]  = e_rs_q;
    assign e_reg[1]  = e_rt_q;

    // Index 0 is the rs operand, index 1 the rt operand.
    for (genvar op = 0; op < 2; op++) begin : g_op
        sb_match u_d_e (
            .valid_i(e_q.valid), .dst_i(e_q.dst), .tnew_i(e_q.tnew),
            .reg_i(d_reg[op]), .tuse_i(d_tuse[op]),
            .match_o(d_e_match[op]), .ready_o(d_e_rdy[op]), .stall_req_o(d_e_stl[op])
        );
        sb_match u_d_m (
            .valid_i(m_q.valid), .dst_i(m_q.dst), .tnew_i(m_q.tnew),
            .reg_i(d_reg[op]), .tuse_i(d_tuse[op]),
            .match_o(d_m_match[op]), .ready_o(d_m_rdy[op]), .stall_req_o(d_m_stl[op])
        );
        sb_match u_e_m (
            .valid_i(m_q.valid), .dst_i(m_q.dst), .tnew_i(m_q.tnew),
            .reg_i(e_reg[op]), .tuse_i(TUSE_NONE),
            .match_o(e_m_match[op]), .ready_o(e_m_rdy[op]), .stall_req_o(e_m_stl[op])
        );
        sb_match u_e_w (
            .valid_i(w_q.valid), .dst_i(w_q.dst), .tnew_i(w_q.tnew),
            .reg_i(e_reg[op]), .tuse_i(TUSE_NONE),
            .match_o(e_w_match[op]), .ready_o(e_w_rdy[op]), .stall_req_o(e_w_stl[op])
        );
    end

    logic sb_unused;
    assign sb_unused = ^{d_e_match, d_m_match, e_m_match, e_m_stl, e_w_rdy, e_w_stl};

    assign data_stall = |{d_e_stl, d_m_stl};
    assign md_stall   = d_is_md && (md_busy || md_start);
    assign stall      = d_valid && (data_stall || md_stall);

    // The nearer producer wins; W is not a D-side source because the regfile already sees it.
    assign fwd_d_rs = d_e_rdy[0] ? FWD_E : (d_m_rdy[0] ? FWD_M : FWD_RF);
    assign fwd_d_rt = d_e_rdy[1] ? FWD_E : (d_m_rdy[1] ? FWD_M : FWD_RF);
    assign fwd_e_rs = e_m_rdy[0] ? FWD_E : (e_w_match[0] ? FWD_W : FWD_RF);
    assign fwd_e_rt = e_m_rdy[1] ? FWD_E : (e_w_match[1] ? FWD_W : FWD_RF);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        e_d    = SB_BUBBLE;
        e_rs_d = 5'd0;
        e_rt_d = 5'd0;
        m_d    = SB_BUBBLE;
        w_d    = SB_BUBBLE;
        if (!req) begin
            w_d       = m_q;
            w_d.tnew  = 2'd0;
            m_d       = e_q;
            m_d.tnew  = tnew_advance(e_q.tnew);
            if (!stall) begin
                e_d.valid = d_valid && (d_dst != 5'd0);
                e_d.dst   = d_dst;
                e_d.tnew  = d_tnew;
                e_rs_d    = d_rs;
                e_rt_d    = d_rt;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all stages advance together.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q    <= SB_BUBBLE;
            m_q    <= SB_BUBBLE;
            w_q    <= SB_BUBBLE;
            e_rs_q <= 5'd0;
            e_rt_q <= 5'd0;
        end else begin
            e_q    <= e_d;
            m_q    <= m_d;
            w_q    <= w_d;
            e_rs_q <= e_rs_d;
            e_rt_q <= e_rt_d;
        end
    end

endmodule
